// File: rtl/vehicle_detector_if.sv
// Loop-detector side of the traffic-light controller: raw loop input and clear
// strobe in, conditioned vehicle request, arrival count and fault flag out.
interface vehicle_detector_if #(
    parameter int CNT_W = 8
);
    logic             LoopSense;
    logic             ClearCount;
    logic             VehiclePresent;
    logic [CNT_W-1:0] VehicleCount;
    logic             Fault;

    modport master (
        output LoopSense,
        output ClearCount,
        input  VehiclePresent,
        input  VehicleCount,
        input  Fault
    );

    modport slave (
        input  LoopSense,
        input  ClearCount,
        output VehiclePresent,
        output VehicleCount,
        output Fault
    );
endinterface

// File: rtl/vehicle_detector.sv
// Synchronises, debounces and stretches the raw loop signal into VehiclePresent,
// counts qualified arrivals (saturating) and flags a loop stuck high.
module vehicle_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int STUCK_CYCLES    = 1024,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    vehicle_detector_if.slave bus
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
    localparam int STK_W  = (STUCK_CYCLES > 1)    ? $clog2(STUCK_CYCLES)    : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STK_W-1:0]  STK_LAST  = STK_W'(STUCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_QUALIFY  = 3'd1;
    localparam logic [2:0] ST_OCCUPIED = 3'd2;
    localparam logic [2:0] ST_HOLD     = 3'd3;
    localparam logic [2:0] ST_FAULT    = 3'd4;

    function automatic logic is_present(input logic [2:0] st);
        return (st == ST_OCCUPIED) || (st == ST_HOLD) || (st == ST_FAULT);
    endfunction

    function automatic logic is_fault(input logic [2:0] st);
        return (st == ST_FAULT);
    endfunction

    logic              sync1_q;
    logic              sync2_q;
    logic              sense_s;
    logic [2:0]        state_q,    state_d;
    logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [STK_W-1:0]  stk_cnt_q,  stk_cnt_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              present_q;
    logic              fault_q;
    logic              arrival_s;

    assign sense_s = sync2_q;

    // Next-state and counter logic; every decision uses the synchronised sample only.
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        stk_cnt_d  = stk_cnt_q;
        arrival_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sense_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = ST_OCCUPIED;
                        stk_cnt_d = '0;
                        arrival_s = 1'b1;
                    end else begin
                        state_d   = ST_QUALIFY;
                        deb_cnt_d = DEB_W'(1);
                    end
                end else begin
                    deb_cnt_d = '0;
                end
            end
            ST_QUALIFY: begin
                if (!sense_s) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                end else if ((deb_cnt_q == DEB_LAST) || (DEBOUNCE_CYCLES == 1)) begin
                    state_d   = ST_OCCUPIED;
                    deb_cnt_d = '0;
                    stk_cnt_d = '0;
                    arrival_s = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            ST_OCCUPIED: begin
                if (!sense_s) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    stk_cnt_d  = '0;
                end else if (stk_cnt_q == STK_LAST) begin
                    state_d   = ST_FAULT;
                    deb_cnt_d = '0;
                    stk_cnt_d = '0;
                end else begin
                    stk_cnt_d = stk_cnt_q + STK_W'(1);
                end
            end
            ST_HOLD: begin
                // Re-detection inside the hold window is the same vehicle: no new count.
                if (sense_s) begin
                    state_d    = ST_OCCUPIED;
                    stk_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_FAULT: begin
                if (sense_s) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                deb_cnt_d  = '0;
                hold_cnt_d = '0;
                stk_cnt_d  = '0;
            end
        endcase
    end

    // Arrival counter: clear takes priority, then a same-cycle arrival counts as one.
    always_comb begin
        count_d = count_q;
        if (bus.ClearCount) begin
            count_d = arrival_s ? CNT_W'(1) : '0;
        end else if (arrival_s && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // State, synchroniser, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= ST_IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            stk_cnt_q  <= '0;
            count_q    <= '0;
            present_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            sync1_q    <= bus.LoopSense;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            stk_cnt_q  <= stk_cnt_d;
            count_q    <= count_d;
            present_q  <= is_present(state_d);
            fault_q    <= is_fault(state_d);
        end
    end

    assign bus.VehiclePresent = present_q;
    assign bus.VehicleCount   = count_q;
    assign bus.Fault          = fault_q;

endmodule

// File: tb/tb_vehicle_detector.sv
// Directed bench for vehicle_detector: expected outputs are queued with the
// edge number at which they must appear and checked as that edge passes.
module tb_vehicle_detector;

    logic clk = 1'b0;
    logic rst;

    vehicle_detector_if #(.CNT_W(2)) bus ();

    vehicle_detector #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (16),
        .STUCK_CYCLES   (64),
        .CNT_W          (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         cyc;
        logic       vp;
        logic [1:0] cnt;
        logic       flt;
    } exp_t;

    exp_t       sb[$];
    int         cyc      = 0;
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [1:0] exp_cnt  = 2'd0;

    function automatic void push(input string tag, input int c, input logic vp,
                                 input logic [1:0] cnt, input logic flt);
        exp_t e;
        e.tag = tag;
        e.cyc = c;
        e.vp  = vp;
        e.cnt = cnt;
        e.flt = flt;
        sb.push_back(e);
    endfunction

    task automatic check_due();
        int   i;
        exp_t e;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                e = sb[i];
                n_assert++;
                assert ((bus.VehiclePresent === e.vp) && (bus.VehicleCount === e.cnt) &&
                        (bus.Fault === e.flt))
                else begin
                    n_fail++;
                    $error("FAIL %s @edge %0d: got vp=%b cnt=%0d fault=%b, expected vp=%b cnt=%0d fault=%b",
                           e.tag, cyc, bus.VehiclePresent, bus.VehicleCount, bus.Fault,
                           e.vp, e.cnt, e.flt);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic tick(input logic ls, input logic cc);
        bus.LoopSense  = ls;
        bus.ClearCount = cc;
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic run(input logic ls, input int n);
        for (int k = 0; k < n; k++) tick(ls, 1'b0);
    endtask

    // One vehicle: hi cycles of loop high then lo (>=19) low; optional clear on the qualifying edge.
    task automatic vehicle(input string tag, input int hi, input int lo, input logic clr_rise);
        int         b;
        logic [1:0] nxt;
        b   = cyc;
        nxt = clr_rise ? 2'd1 : ((exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1);
        push({tag, "_pre"},  b + 5,       1'b0, exp_cnt, 1'b0);
        push({tag, "_rise"}, b + 6,       1'b1, nxt,     1'b0);
        push({tag, "_hold"}, b + hi + 18, 1'b1, nxt,     1'b0);
        push({tag, "_fall"}, b + hi + 19, 1'b0, nxt,     1'b0);
        for (int k = 1; k <= hi + lo; k++) tick(k <= hi, clr_rise && (k == 6));
        exp_cnt = nxt;
    endtask

    initial begin
        int b;
        bus.LoopSense  = 1'b0;
        bus.ClearCount = 1'b0;
        rst            = 1'b0;

        // Reset held for three edges
        for (int k = 1; k <= 3; k++) push("reset", k, 1'b0, 2'd0, 1'b0);
        run(1'b0, 3);
        rst = 1'b1;
        run(1'b0, 4);

        // Three-cycle glitch must be rejected
        b = cyc;
        push("glitch_a", b + 5,  1'b0, 2'd0, 1'b0);
        push("glitch_b", b + 8,  1'b0, 2'd0, 1'b0);
        push("glitch_c", b + 12, 1'b0, 2'd0, 1'b0);
        run(1'b1, 3);
        run(1'b0, 10);

        vehicle("single", 20, 24, 1'b0);

        // 8-cycle gap bridged into one pulse, one count
        b = cyc;
        push("gap8_rise", b + 6,  1'b1, 2'd2, 1'b0);
        push("gap8_low",  b + 15, 1'b1, 2'd2, 1'b0);
        push("gap8_bri",  b + 20, 1'b1, 2'd2, 1'b0);
        push("gap8_hi2",  b + 25, 1'b1, 2'd2, 1'b0);
        push("gap8_hold", b + 46, 1'b1, 2'd2, 1'b0);
        push("gap8_fall", b + 47, 1'b0, 2'd2, 1'b0);
        run(1'b1, 10);
        run(1'b0, 8);
        run(1'b1, 10);
        run(1'b0, 24);
        exp_cnt = 2'd2;

        push("clr_alone", cyc + 1, 1'b0, 2'd0, 1'b0);
        tick(1'b0, 1'b1);
        exp_cnt = 2'd0;

        // 20-cycle gap splits into two pulses, two counts
        b = cyc;
        push("gap20_rise1", b + 6,  1'b1, 2'd1, 1'b0);
        push("gap20_hold",  b + 28, 1'b1, 2'd1, 1'b0);
        push("gap20_drop",  b + 29, 1'b0, 2'd1, 1'b0);
        push("gap20_pre2",  b + 35, 1'b0, 2'd1, 1'b0);
        push("gap20_rise2", b + 36, 1'b1, 2'd2, 1'b0);
        push("gap20_hold2", b + 58, 1'b1, 2'd2, 1'b0);
        push("gap20_fall",  b + 59, 1'b0, 2'd2, 1'b0);
        run(1'b1, 10);
        run(1'b0, 20);
        run(1'b1, 10);
        run(1'b0, 24);
        exp_cnt = 2'd2;

        // Stuck loop: fault 64 edges after occupied entry, clears after 4 low samples
        b = cyc;
        push("stk_rise",    b + 6,  1'b1, 2'd3, 1'b0);
        push("stk_pre",     b + 69, 1'b1, 2'd3, 1'b0);
        push("stk_fault",   b + 70, 1'b1, 2'd3, 1'b1);
        push("stk_mid",     b + 80, 1'b1, 2'd3, 1'b1);
        push("stk_rel_pre", b + 85, 1'b1, 2'd3, 1'b1);
        push("stk_rel",     b + 86, 1'b0, 2'd3, 1'b0);
        run(1'b1, 80);
        run(1'b0, 10);
        exp_cnt = 2'd3;

        // Saturation 1,2,3,3,3 then clear coinciding with an arrival
        push("clr_alone2", cyc + 1, 1'b0, 2'd0, 1'b0);
        tick(1'b0, 1'b1);
        exp_cnt = 2'd0;
        for (int v = 0; v < 5; v++) vehicle("sat", 8, 24, 1'b0);
        vehicle("clr_arrive", 8, 24, 1'b1);

        // Reset during HOLD
        b = cyc;
        push("rh_rise", b + 6,  1'b1, 2'd2, 1'b0);
        push("rh_hold", b + 15, 1'b1, 2'd2, 1'b0);
        push("rh_rst",  b + 16, 1'b0, 2'd0, 1'b0);
        run(1'b1, 10);
        run(1'b0, 5);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        rst = 1'b1;
        exp_cnt = 2'd0;
        run(1'b0, 3);
        vehicle("after_rh", 8, 24, 1'b0);

        // Reset during FAULT with the loop still high
        b = cyc;
        push("rf_rise",  b + 6,  1'b1, 2'd2, 1'b0);
        push("rf_fault", b + 70, 1'b1, 2'd2, 1'b1);
        push("rf_rst",   b + 76, 1'b0, 2'd0, 1'b0);
        run(1'b1, 75);
        rst = 1'b0;
        tick(1'b1, 1'b0);
        rst = 1'b1;
        exp_cnt = 2'd0;
        vehicle("after_rf", 8, 24, 1'b0);

        n_assert++;
        assert (sb.size() == 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
